// File: rtl/mips_multicycle_ctrl.sv
// Multicycle MIPS sequencer; 3-5 cycles/instr plus one per memory wait cycle; stalls in memory states until mem_ready.
// Define MIPS_JUMP_EN to decode J (opcode 000010) into JEX; otherwise J is illegal.
module mips_multicycle_ctrl (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic       zero,
   input  logic       mem_ready,
   output logic       mem_req,
   output logic       mem_write,
   output logic       iord,
   output logic       ir_write,
   output logic       pc_write,
   output logic [1:0] pc_src,
   output logic       alu_src_a,
   output logic [1:0] alu_src_b,
   output logic [2:0] alu_ctrl,
   output logic       reg_dst,
   output logic       mem_to_reg,
   output logic       reg_write,
   output logic       instr_done,
   output logic       illegal
);

   localparam logic [3:0] S_IDLE    = 4'd0;
   localparam logic [3:0] S_FETCH   = 4'd1;
   localparam logic [3:0] S_DECODE  = 4'd2;
   localparam logic [3:0] S_MEMADR  = 4'd3;
   localparam logic [3:0] S_MEMRD   = 4'd4;
   localparam logic [3:0] S_MEMWB   = 4'd5;
   localparam logic [3:0] S_MEMWR   = 4'd6;
   localparam logic [3:0] S_RTYPEEX = 4'd7;
   localparam logic [3:0] S_ALUWB   = 4'd8;
   localparam logic [3:0] S_BEQEX   = 4'd9;
   localparam logic [3:0] S_ADDIEX  = 4'd10;
   localparam logic [3:0] S_ADDIWB  = 4'd11;
`ifdef MIPS_JUMP_EN
   localparam logic [3:0] S_JEX     = 4'd12;
   localparam logic [5:0] OP_J      = 6'b000010;
`endif

   localparam logic [5:0] OP_RTYPE = 6'b000000;
   localparam logic [5:0] OP_LW    = 6'b100011;
   localparam logic [5:0] OP_SW    = 6'b101011;
   localparam logic [5:0] OP_BEQ   = 6'b000100;
   localparam logic [5:0] OP_ADDI  = 6'b001000;

   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_SLT = 3'b111;

   logic [3:0] state;
   logic [3:0] state_nxt;
   logic       funct_ok;
   logic [2:0] rtype_alu;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      funct_ok  = 1'b1;
      rtype_alu = ALU_ADD;
      case (funct)
         6'b100000: rtype_alu = ALU_ADD;
         6'b100010: rtype_alu = ALU_SUB;
         6'b100100: rtype_alu = ALU_AND;
         6'b100101: rtype_alu = ALU_OR;
         6'b101010: rtype_alu = ALU_SLT;
         default:   funct_ok  = 1'b0;
      endcase
   end

   always_comb begin
      state_nxt  = state;
      mem_req    = 1'b0;
      mem_write  = 1'b0;
      iord       = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 2'b00;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'b00;
      alu_ctrl   = ALU_ADD;
      reg_dst    = 1'b0;
      mem_to_reg = 1'b0;
      reg_write  = 1'b0;
      instr_done = 1'b0;
      illegal    = 1'b0;
      case (state)
         S_IDLE: begin
            alu_ctrl  = 3'b000;
            state_nxt = S_FETCH;
         end
         S_FETCH: begin
            mem_req   = 1'b1;
            alu_src_b = 2'b01;
            ir_write  = mem_ready;
            pc_write  = mem_ready;
            if (mem_ready) state_nxt = S_DECODE;
         end
         // Branch target is precomputed here while the opcode is decoded.
         S_DECODE: begin
            alu_src_b = 2'b11;
            case (opcode)
               OP_LW, OP_SW: state_nxt = S_MEMADR;
               OP_BEQ:       state_nxt = S_BEQEX;
               OP_ADDI:      state_nxt = S_ADDIEX;
`ifdef MIPS_JUMP_EN
               OP_J:         state_nxt = S_JEX;
`endif
               OP_RTYPE: begin
                  if (funct_ok) state_nxt = S_RTYPEEX;
                  else begin
                     illegal   = 1'b1;
                     state_nxt = S_FETCH;
                  end
               end
               default: begin
                  illegal   = 1'b1;
                  state_nxt = S_FETCH;
               end
            endcase
         end
         S_MEMADR: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            state_nxt = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
         end
         S_MEMRD: begin
            mem_req = 1'b1;
            iord    = 1'b1;
            if (mem_ready) state_nxt = S_MEMWB;
         end
         S_MEMWB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            instr_done = 1'b1;
            state_nxt  = S_FETCH;
         end
         S_MEMWR: begin
            mem_req    = 1'b1;
            mem_write  = 1'b1;
            iord       = 1'b1;
            instr_done = mem_ready;
            if (mem_ready) state_nxt = S_FETCH;
         end
         S_RTYPEEX: begin
            alu_src_a = 1'b1;
            alu_ctrl  = rtype_alu;
            state_nxt = S_ALUWB;
         end
         S_ALUWB: begin
            reg_write  = 1'b1;
            reg_dst    = 1'b1;
            instr_done = 1'b1;
            state_nxt  = S_FETCH;
         end
         S_BEQEX: begin
            alu_src_a  = 1'b1;
            alu_ctrl   = ALU_SUB;
            pc_src     = 2'b01;
            pc_write   = zero;
            instr_done = 1'b1;
            state_nxt  = S_FETCH;
         end
         S_ADDIEX: begin
            alu_src_a = 1'b1;
            alu_src_b = 2'b10;
            state_nxt = S_ADDIWB;
         end
         S_ADDIWB: begin
            reg_write  = 1'b1;
            instr_done = 1'b1;
            state_nxt  = S_FETCH;
         end
`ifdef MIPS_JUMP_EN
         S_JEX: begin
            pc_src     = 2'b10;
            pc_write   = 1'b1;
            instr_done = 1'b1;
            state_nxt  = S_FETCH;
         end
`endif
         default: begin
            alu_ctrl  = 3'b000;
            state_nxt = S_IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for mips_multicycle_ctrl: per-instruction cycle counts and per-state output snapshots.
module tb_mips_multicycle_ctrl;

   logic       clk;
   logic       rst_n;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic       zero;
   logic       mem_ready;
   logic       mem_req, mem_write, iord, ir_write, pc_write;
   logic [1:0] pc_src;
   logic       alu_src_a;
   logic [1:0] alu_src_b;
   logic [2:0] alu_ctrl;
   logic       reg_dst, mem_to_reg, reg_write, instr_done, illegal;

   typedef struct packed {
      logic       mem_req;
      logic       mem_write;
      logic       iord;
      logic       pc_write;
      logic [1:0] pc_src;
      logic [2:0] alu_ctrl;
      logic       reg_dst;
      logic       mem_to_reg;
      logic       reg_write;
      logic       illegal;
   } snap_t;

   snap_t snap [64];
   int    n_chk = 0;
   int    n_err = 0;
   int    cyc, dones, ills, we;

   mips_multicycle_ctrl dut (
      .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct(funct), .zero(zero),
      .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write), .iord(iord),
      .ir_write(ir_write), .pc_write(pc_write), .pc_src(pc_src), .alu_src_a(alu_src_a),
      .alu_src_b(alu_src_b), .alu_ctrl(alu_ctrl), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
      .reg_write(reg_write), .instr_done(instr_done), .illegal(illegal)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Runs one instruction starting in FETCH; the data access is held off for 'waits' cycles.
   task automatic run(input logic [5:0] op, input logic [5:0] fn, input logic z, input int waits);
      int w;
      w      = 0;
      cyc    = 0;
      dones  = 0;
      ills   = 0;
      we     = 0;
      opcode = op;
      funct  = fn;
      zero   = z;
      while (cyc < 40) begin
         if (mem_req && iord && w < waits) begin
            mem_ready = 1'b0;
            w++;
         end else begin
            mem_ready = 1'b1;
         end
         #1;
         snap[cyc] = {mem_req, mem_write, iord, pc_write, pc_src, alu_ctrl,
                      reg_dst, mem_to_reg, reg_write, illegal};
         dones += int'(instr_done);
         ills  += int'(illegal);
         if (cyc > 0) we += int'(reg_write | mem_write | pc_write);
         cyc++;
         tick();
         if (mem_req && !iord) break;
      end
      if (cyc >= 40) check("timeout", cyc, 0);
   endtask

   initial begin
      rst_n     = 1'b0;
      opcode    = 6'b000000;
      funct     = 6'b100000;
      zero      = 1'b0;
      mem_ready = 1'b1;
      #8;
      check("rst_mem_req", mem_req, 0);
      check("rst_ir_write", ir_write, 0);
      check("rst_pc_write", pc_write, 0);
      check("rst_alu_ctrl", alu_ctrl, 3'b000);
      #4;
      rst_n = 1'b1;
      #1;
      check("idle_mem_req", mem_req, 0);
      tick();
      check("fetch_mem_req", mem_req, 1);
      check("fetch_ir_write", ir_write, 1);
      check("fetch_pc_write", pc_write, 1);
      check("fetch_alu_src_b", alu_src_b, 2'b01);
      check("fetch_alu_ctrl", alu_ctrl, 3'b010);

      run(6'b100011, 6'b000000, 1'b0, 2);
      check("lw_cycles", cyc, 7);
      check("lw_dones", dones, 1);
      check("lw_rd_stable", {snap[3].mem_req, snap[3].iord, snap[5].mem_req, snap[5].iord}, 4'b1111);
      check("lw_wb_reg_write", snap[6].reg_write, 1);
      check("lw_wb_mem_to_reg", snap[6].mem_to_reg, 1);
      check("lw_wb_reg_dst", snap[6].reg_dst, 0);

      run(6'b000000, 6'b100010, 1'b0, 0);
      check("sub_cycles", cyc, 4);
      check("sub_alu_ctrl", snap[2].alu_ctrl, 3'b110);
      check("sub_reg_dst", snap[3].reg_dst, 1);
      run(6'b000000, 6'b101010, 1'b0, 0);
      check("slt_cycles", cyc, 4);
      check("slt_alu_ctrl", snap[2].alu_ctrl, 3'b111);
      check("slt_reg_dst", snap[3].reg_dst, 1);

      run(6'b000100, 6'b000000, 1'b1, 0);
      check("beq_t_cycles", cyc, 3);
      check("beq_t_pc_write", snap[2].pc_write, 1);
      check("beq_t_pc_src", snap[2].pc_src, 2'b01);
      check("beq_t_alu_ctrl", snap[2].alu_ctrl, 3'b110);
      run(6'b000100, 6'b000000, 1'b0, 0);
      check("beq_nt_cycles", cyc, 3);
      check("beq_nt_pc_write", snap[2].pc_write, 0);
      check("beq_nt_dones", dones, 1);

      run(6'b001000, 6'b000000, 1'b0, 0);
      check("addi_cycles", cyc, 4);
      check("addi_wb", {snap[3].reg_write, snap[3].reg_dst}, 2'b10);

      run(6'b111111, 6'b000000, 1'b0, 0);
      check("ill_op_cycles", cyc, 2);
      check("ill_op_pulse", {snap[1].illegal, 6'(ills)}, {1'b1, 6'd1});
      check("ill_op_writes", we, 0);
      run(6'b000000, 6'b000111, 1'b0, 0);
      check("ill_fn_cycles", cyc, 2);
      check("ill_fn_pulse", {snap[1].illegal, 6'(ills)}, {1'b1, 6'd1});
      check("ill_fn_writes", we, 0);

      opcode    = 6'b101011;
      mem_ready = 1'b1;
      tick();
      tick();
      mem_ready = 1'b0;
      tick();
      check("sw_wr_req", {mem_req, mem_write, iord, instr_done}, 4'b1110);
      tick();
      check("sw_wr_hold", {mem_req, mem_write, iord}, 3'b111);
      #2;
      rst_n = 1'b0;
      #1;
      check("sw_rst_drop", {mem_req, mem_write, reg_write, pc_write}, 4'b0000);
      check("sw_rst_idle_alu", alu_ctrl, 3'b000);
      tick();
      check("sw_rst_held", mem_req, 0);
      rst_n     = 1'b1;
      mem_ready = 1'b1;
      #1;
      check("sw_rst_idle", {mem_req, alu_ctrl}, 4'b0000);
      tick();
      check("sw_rst_fetch", {mem_req, iord}, 2'b10);

      run(6'b000010, 6'b000000, 1'b0, 0);
`ifdef MIPS_JUMP_EN
      check("j_cycles", cyc, 3);
      check("j_pc_write", snap[2].pc_write, 1);
      check("j_pc_src", snap[2].pc_src, 2'b10);
      check("j_dones", dones, 1);
`else
      check("j_cycles", cyc, 2);
      check("j_illegal", snap[1].illegal, 1);
      check("j_writes", we, 0);
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Multicycle sequencer for the MIPS core. It replaces single-cycle decode with a Moore/Mealy FSM that steps a shared-memory datapath through fetch, decode, execute, memory and writeback. Every step drives the datapath mux selects, ALU control and write enables. The memory port has a request/ready handshake, so the controller stalls in any memory state until the memory acknowledges.

## Interface
- No parameters; all encodings are fixed below.
- clk  in  1  core clock; all state updates on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- opcode  in  6  instr[31:26] from the instruction register.
- funct  in  6  instr[5:0] from the instruction register.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completed the current access this cycle.
- mem_req  out  1  memory access requested.
- mem_write  out  1  store; valid only while mem_req=1.
- iord  out  1  memory address select: 0 = PC, 1 = ALU result register.
- ir_write  out  1  load the instruction register.
- pc_write  out  1  load the PC; covers both unconditional and taken-branch writes.
- pc_src  out  2  next-PC select: 00 = ALU, 01 = ALUOut (branch target), 10 = jump target.
- alu_src_a  out  1  0 = PC, 1 = register A.
- alu_src_b  out  2  00 = register B, 01 = constant 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- alu_ctrl  out  3  ADD=010, SUB=110, AND=000, OR=001, SLT=111.
- reg_dst  out  1  1 = rd, 0 = rt.
- mem_to_reg  out  1  1 = memory data register, 0 = ALUOut.
- reg_write  out  1  register file write enable.
- instr_done  out  1  one-cycle pulse in the final state of each retired instruction.
- illegal  out  1  one-cycle pulse in the DECODE cycle on an unsupported opcode or funct.

## Operation
- Opcodes: R_TYPE=000000, LW=100011, SW=101011, BEQ=000100, ADDI=001000, J=000010 (J only with the macro).
- R-type funct codes: ADD=100000, SUB=100010, AND=100100, OR=100101, SLT=101010.
- States and their non-zero outputs. Any output not listed for a state is 0.
  - IDLE: all outputs 0. Go to FETCH.
  - FETCH: mem_req=1; alu_src_b=01; alu_ctrl=ADD; ir_write=pc_write=mem_ready. Stay in FETCH while mem_ready=0; go to DECODE when mem_ready=1.
  - DECODE: alu_src_b=11; alu_ctrl=ADD (precomputes the branch target). Next state by opcode:
    - LW or SW: MEMADR.
    - R_TYPE: RTYPEEX.
    - BEQ: BEQEX.
    - ADDI: ADDIEX.
    - J: JEX.
    - Any other opcode: illegal=1, go to FETCH.
    - R_TYPE with an unlisted funct: illegal=1, go to FETCH.
  - MEMADR: alu_src_a=1; alu_src_b=10; ADD. Go to MEMRD for LW, MEMWR for SW.
  - MEMRD: mem_req=1; iord=1. Stay until mem_ready=1, then go to MEMWB.
  - MEMWB: reg_write=1; mem_to_reg=1; reg_dst=0; instr_done=1. Go to FETCH.
  - MEMWR: mem_req=1; mem_write=1; iord=1. Stay until mem_ready=1, then go to FETCH with instr_done=mem_ready.
  - RTYPEEX: alu_src_a=1; alu_src_b=00; alu_ctrl decoded from funct. Go to ALUWB.
  - ALUWB: reg_write=1; reg_dst=1; instr_done=1. Go to FETCH.
  - BEQEX: alu_src_a=1; alu_src_b=00; SUB; pc_src=01; pc_write=zero; instr_done=1. Go to FETCH.
  - ADDIEX: alu_src_a=1; alu_src_b=10; ADD. Go to ADDIWB.
  - ADDIWB: reg_write=1; reg_dst=0; instr_done=1. Go to FETCH.
  - JEX: pc_src=10; pc_write=1; instr_done=1. Go to FETCH.
- In states with no ALU activity, alu_ctrl is 010.

## Timing
- Reset:
  - rst_n low forces IDLE asynchronously; all outputs 0 while in reset.
  - FETCH is entered on the first rising edge with rst_n high.
- Reset asserted mid-instruction or mid-access: the FSM returns to IDLE immediately and mem_req drops in the same cycle. No partial write-enable pulse may appear after reset is asserted.
- Mealy outputs (ir_write, pc_write in FETCH, pc_write in BEQEX, MEMWR's instr_done) are combinational from mem_ready or zero in the current cycle.
- All other outputs are decoded from the current state only.
- Cycles per instruction with zero wait states: R=4, LW=5, SW=4, BEQ=3, ADDI=4, J=3.
- Each memory wait cycle adds one cycle.
- Handshake: mem_req, iord and mem_write hold stable while waiting. mem_ready is ignored when mem_req=0.
- Illegal opcode: 2 cycles total (FETCH, DECODE). No state-changing write enable is asserted.

## Configuration
- MIPS_JUMP_EN defined: opcode 000010 decodes to JEX, and pc_src=10 is produced there.
- MIPS_JUMP_EN undefined:
  - JEX is not implemented.
  - Opcode 000010 raises illegal and returns to FETCH.
  - pc_src never takes the value 10.

## Test plan
- Reset, then release with mem_ready=1: IDLE lasts one cycle. FETCH then shows mem_req=1, ir_write=1, pc_write=1, alu_src_b=01, alu_ctrl=010.
- LW (opcode 100011) with mem_ready low for 2 cycles in MEMRD: total 7 cycles. MEMWB shows reg_write=1, mem_to_reg=1, reg_dst=0. instr_done pulses once.
- R-type SUB (funct 100010) versus SLT (funct 101010): RTYPEEX shows alu_ctrl=110 and 111 respectively. ALUWB shows reg_dst=1. Each takes 4 cycles.
- BEQ with zero=1, then with zero=0: BEQEX shows pc_write=1, pc_src=01 in the first case; pc_write=0 in the second. Each takes 3 cycles.
- Opcode 111111, then R-type funct 000111: illegal pulses in DECODE, the FSM returns to FETCH, and reg_write, mem_write and pc_write stay 0 after FETCH.
- SW with reset asserted during the MEMWR wait, then opcode 000010 under each macro setting:
  - SW reset case: mem_req and mem_write drop immediately and the FSM restarts at IDLE.
  - Opcode 000010 with MIPS_JUMP_EN defined: JEX with pc_write=1, pc_src=10.
  - Opcode 000010 with MIPS_JUMP_EN undefined: illegal=1.
